bitxor_ctrl: RTL and testbench



---
 rtl/bitxor_ctrl_if.sv | 40 ++++
 rtl/bitxor_ctrl.sv | 169 ++++++++++++++++
 tb/tb_bitxor_ctrl.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bitxor_ctrl_if.sv
// Host/register-file bundle for the XOR register-file command sequencer.
// Latency: none; this is wiring only.
// Backpressure: req_valid/req_ready on the request side, resp_valid/resp_ready on the response side.
//
// Signals:
//   req_valid/req_ready  host request handshake
//   req_op/req_l/req_r/req_val  request fields (op, low/update index, high index, update value)
//   resp_valid/resp_ready/resp_data  range-XOR result handshake
//   inst/idx/xorval      register-file command bus (driven by the sequencer)
//   rangexor             register-file combinational prefix-XOR result
//
// master: the environment side (host plus register file).
// slave:  the sequencer side.
interface bitxor_ctrl_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [2:0] req_l;
    logic [2:0] req_r;
    logic       req_val;

    logic       resp_valid;
    logic       resp_ready;
    logic       resp_data;

    logic [1:0] inst;
    logic [2:0] idx;
    logic       xorval;
    logic       rangexor;

    modport master (
        output req_valid, req_op, req_l, req_r, req_val, resp_ready, rangexor,
        input  req_ready, resp_valid, resp_data, inst, idx, xorval
    );

    modport slave (
        input  req_valid, req_op, req_l, req_r, req_val, resp_ready, rangexor,
        output req_ready, resp_valid, resp_data, inst, idx, xorval
    );
endinterface

// File: rtl/bitxor_ctrl.sv
// Sequencer turning host update / range-XOR / clear-all requests into register-file bus operations.
// Latency from accept edge: update 1 bus cycle; query 1 (l>r), 2 (l==0) or 3 (l>0) cycles to resp_valid; clear 16 bus cycles.
// Backpressure: req_ready only in IDLE; the response is held stable in RESP until resp_ready.
//
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous active-high reset
//   bus    bitxor_ctrl_if.slave: host request/response channels and register-file inst/idx/xorval/rangexor
module bitxor_ctrl (
    input  logic          clk,
    input  logic          reset,
    bitxor_ctrl_if.slave  bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_UPD    = 3'd1;
    localparam logic [2:0] S_QR     = 3'd2;
    localparam logic [2:0] S_QL     = 3'd3;
    localparam logic [2:0] S_CLR_RD = 3'd4;
    localparam logic [2:0] S_CLR_WR = 3'd5;
    localparam logic [2:0] S_RESP   = 3'd6;

    localparam logic [1:0] OP_UPD   = 2'b00;
    localparam logic [1:0] OP_QRY   = 2'b01;
    localparam logic [1:0] OP_CLR   = 2'b10;

    localparam logic [1:0] INST_UPD = 2'b00;
    localparam logic [1:0] INST_QRY = 2'b01;
    localparam logic [1:0] INST_NOP = 2'b11;

    logic [2:0] state,    state_n;
    logic [2:0] l_q,      l_n;
    logic       acc,      acc_n;
    logic [2:0] clr_i,    clr_i_n;
    logic [1:0] inst_q,   inst_n;
    logic [2:0] idx_q,    idx_n;
    logic       xorval_q, xorval_n;

    // The bus registers are loaded with the command belonging to the state
    // being entered, so each state's bus value is visible during that state
    // and the register file acts on it at the state's closing edge.
    always_comb begin
        state_n  = state;
        l_n      = l_q;
        acc_n    = acc;
        clr_i_n  = clr_i;
        inst_n   = INST_NOP;
        idx_n    = 3'd0;
        xorval_n = 1'b0;

        case (state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    l_n = bus.req_l;
                    case (bus.req_op)
                        OP_UPD: begin
                            state_n  = S_UPD;
                            inst_n   = INST_UPD;
                            idx_n    = bus.req_l;
                            xorval_n = bus.req_val;
                        end
                        OP_QRY: begin
                            if (bus.req_l > bus.req_r) begin
                                // Empty range: answer 0 without touching the register file.
                                acc_n   = 1'b0;
                                state_n = S_RESP;
                            end else begin
                                state_n = S_QR;
                                inst_n  = INST_QRY;
                                idx_n   = bus.req_r;
                            end
                        end
                        OP_CLR: begin
                            clr_i_n = 3'd0;
                            state_n = S_CLR_RD;
                            inst_n  = INST_QRY;
                            idx_n   = 3'd0;
                        end
                        default: begin
                            // Reserved op: accepted and dropped.
                            state_n = S_IDLE;
                        end
                    endcase
                end
            end

            S_UPD: begin
                state_n = S_IDLE;
            end

            S_QR: begin
                acc_n = bus.rangexor;
                if (l_q == 3'd0) begin
                    // Prefix below entry 0 is empty, so prefix(r) is the answer.
                    state_n = S_RESP;
                end else begin
                    state_n = S_QL;
                    inst_n  = INST_QRY;
                    idx_n   = l_q - 3'd1;
                end
            end

            S_QL: begin
                acc_n   = acc ^ bus.rangexor;
                state_n = S_RESP;
            end

            S_RESP: begin
                if (bus.resp_ready) begin
                    state_n = S_IDLE;
                end
            end

            S_CLR_RD: begin
                // Entries below clr_i are already zero, so the prefix equals
                // entry clr_i; XORing it back in clears the entry.
                state_n  = S_CLR_WR;
                inst_n   = INST_UPD;
                idx_n    = clr_i;
                xorval_n = bus.rangexor;
            end

            S_CLR_WR: begin
                if (clr_i == 3'd7) begin
                    clr_i_n = 3'd0;
                    state_n = S_IDLE;
                end else begin
                    clr_i_n = clr_i + 3'd1;
                    state_n = S_CLR_RD;
                    inst_n  = INST_QRY;
                    idx_n   = clr_i + 3'd1;
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            l_q      <= 3'd0;
            acc      <= 1'b0;
            clr_i    <= 3'd0;
            inst_q   <= INST_NOP;
            idx_q    <= 3'd0;
            xorval_q <= 1'b0;
        end else begin
            state    <= state_n;
            l_q      <= l_n;
            acc      <= acc_n;
            clr_i    <= clr_i_n;
            inst_q   <= inst_n;
            idx_q    <= idx_n;
            xorval_q <= xorval_n;
        end
    end

    // Ready is masked by reset so the host sees no acceptance while reset is held.
    assign bus.req_ready  = (state == S_IDLE) && !reset;
    assign bus.resp_valid = (state == S_RESP);
    assign bus.resp_data  = acc;
    assign bus.inst       = inst_q;
    assign bus.idx        = idx_q;
    assign bus.xorval     = xorval_q;

endmodule

// File: tb/tb_bitxor_ctrl.sv
// Self-checking bench for bitxor_ctrl with a behavioural 8x1 XOR register file.
// Latency: checks exact per-cycle bus sequences and response timing after each accept.
// Backpressure: holds resp_ready low to check response stability and req_ready gating.
module tb_bitxor_ctrl;

    localparam logic [1:0] OP_UPD = 2'b00;
    localparam logic [1:0] OP_QRY = 2'b01;
    localparam logic [1:0] OP_CLR = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    logic clk;
    logic reset;

    bitxor_ctrl_if bus ();

    bitxor_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural register file: update on the edge, prefix query combinational.
    logic [7:0] rf = 8'h00;
    logic       rx;

    always @(posedge clk) begin
        if (bus.inst == 2'b00) rf[bus.idx] <= rf[bus.idx] ^ bus.xorval;
    end

    always_comb begin
        rx = 1'b0;
        if (bus.inst == 2'b01) begin
            for (int k = 0; k < 8; k++) begin
                if (k <= int'(bus.idx)) rx = rx ^ rf[k];
            end
        end
    end
    assign bus.rangexor = rx;

    // Request-level shadow of the register-file contents and response scoreboard.
    logic [7:0] shadow;
    logic       exp_q[$];
    int         n_chk  = 0;
    int         n_fail = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic ref_xor(input logic [2:0] l, input logic [2:0] r);
        logic x;
        x = 1'b0;
        if (l > r) return 1'b0;
        for (int k = int'(l); k <= int'(r); k++) x = x ^ shadow[k];
        return x;
    endfunction

    // Waits for req_ready, presents one request and returns at the accept edge + 1.
    // When model is set the shadow is updated and any expected response is queued.
    task automatic issue(input logic [1:0] op, input logic [2:0] l, input logic [2:0] r,
                         input logic v, input bit model);
        int n;
        n = 0;
        @(posedge clk); #1;
        while (!bus.req_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("req_ready_wait", int'(bus.req_ready), 1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_l     = l;
        bus.req_r     = r;
        bus.req_val   = v;
        if (model) begin
            case (op)
                OP_UPD:  shadow[l] = shadow[l] ^ v;
                OP_QRY:  exp_q.push_back(ref_xor(l, r));
                OP_CLR:  shadow = 8'h00;
                default: ;
            endcase
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !bus.req_ready) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    // Response monitor: a transfer completes on the edge following a negedge with valid && ready.
    always @(negedge clk) begin
        if (!reset && bus.resp_valid && bus.resp_ready) begin
            if (exp_q.size() == 0) chk("resp_unexpected", exp_q.size(), 1);
            else                   chk("resp_data", int'(bus.resp_data), int'(exp_q.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] pat;
        logic       e;

        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_op     = 2'b00;
        bus.req_l      = 3'd0;
        bus.req_r      = 3'd0;
        bus.req_val    = 1'b0;
        bus.resp_ready = 1'b1;
        shadow         = 8'h00;

        // Reset behaviour.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready_low", int'(bus.req_ready), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_req_ready",  int'(bus.req_ready),  1);
        chk("rst_resp_valid", int'(bus.resp_valid), 0);
        chk("rst_resp_data",  int'(bus.resp_data),  0);
        chk("rst_inst",       int'(bus.inst),       3);
        chk("rst_idx",        int'(bus.idx),        0);
        chk("rst_xorval",     int'(bus.xorval),     0);

        // Single update, exactly one bus cycle.
        issue(OP_UPD, 3'd3, 3'd0, 1'b1, 1);
        @(negedge clk);
        chk("upd_inst",   int'(bus.inst),   0);
        chk("upd_idx",    int'(bus.idx),    3);
        chk("upd_xorval", int'(bus.xorval), 1);
        @(negedge clk);
        chk("upd_end_inst",  int'(bus.inst),      3);
        chk("upd_end_ready", int'(bus.req_ready), 1);

        // Query 3..3: QR idx 3, QL idx 2, response in cycle 3.
        issue(OP_QRY, 3'd3, 3'd3, 1'b0, 1);
        @(negedge clk);
        chk("q33_qr_inst", int'(bus.inst), 1);
        chk("q33_qr_idx",  int'(bus.idx),  3);
        @(negedge clk);
        chk("q33_ql_inst",  int'(bus.inst),       1);
        chk("q33_ql_idx",   int'(bus.idx),        2);
        chk("q33_ql_valid", int'(bus.resp_valid), 0);
        @(negedge clk);
        chk("q33_resp_valid", int'(bus.resp_valid), 1);
        chk("q33_resp_inst",  int'(bus.inst),       3);
        wait_idle();

        // Entries {1,4,6}.
        issue(OP_UPD, 3'd3, 3'd0, 1'b1, 1);
        issue(OP_UPD, 3'd1, 3'd0, 1'b1, 1);
        issue(OP_UPD, 3'd4, 3'd0, 1'b1, 1);
        issue(OP_UPD, 3'd6, 3'd0, 1'b1, 1);
        wait_idle();

        issue(OP_QRY, 3'd2, 3'd6, 1'b0, 1);
        @(negedge clk);
        chk("q26_qr_idx", int'(bus.idx), 6);
        @(negedge clk);
        chk("q26_ql_inst", int'(bus.inst), 1);
        chk("q26_ql_idx",  int'(bus.idx),  1);
        wait_idle();

        issue(OP_QRY, 3'd0, 3'd4, 1'b0, 1);
        @(negedge clk);
        chk("q04_qr_idx", int'(bus.idx), 4);
        @(negedge clk);
        chk("q04_no_ql_inst", int'(bus.inst),       3);
        chk("q04_resp_valid", int'(bus.resp_valid), 1);
        wait_idle();

        issue(OP_QRY, 3'd5, 3'd7, 1'b0, 1);
        wait_idle();

        // Empty range: response one cycle after accept, register file untouched.
        issue(OP_QRY, 3'd5, 3'd2, 1'b0, 1);
        @(negedge clk);
        chk("q52_resp_valid", int'(bus.resp_valid), 1);
        chk("q52_inst",       int'(bus.inst),       3);
        wait_idle();

        // Reserved op: no bus activity, no response.
        issue(OP_RSV, 3'd1, 3'd2, 1'b1, 1);
        @(negedge clk);
        chk("rsv_inst",       int'(bus.inst),       3);
        chk("rsv_ready",      int'(bus.req_ready),  1);
        chk("rsv_resp_valid", int'(bus.resp_valid), 0);

        // Backpressure on the response channel.
        bus.resp_ready = 1'b0;
        e = ref_xor(3'd0, 3'd6);
        issue(OP_QRY, 3'd0, 3'd6, 1'b0, 1);
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("bp_resp_valid", int'(bus.resp_valid), 1);
            chk("bp_resp_data",  int'(bus.resp_data),  int'(e));
            chk("bp_req_ready",  int'(bus.req_ready),  0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_done_valid", int'(bus.resp_valid), 0);
        chk("bp_done_ready", int'(bus.req_ready),  1);

        // Clear-all with entries {0,2,7} set.
        issue(OP_UPD, 3'd1, 3'd0, 1'b1, 1);
        issue(OP_UPD, 3'd4, 3'd0, 1'b1, 1);
        issue(OP_UPD, 3'd6, 3'd0, 1'b1, 1);
        issue(OP_UPD, 3'd0, 3'd0, 1'b1, 1);
        issue(OP_UPD, 3'd2, 3'd0, 1'b1, 1);
        issue(OP_UPD, 3'd7, 3'd0, 1'b1, 1);
        pat = 8'b1000_0101;
        issue(OP_CLR, 3'd0, 3'd0, 1'b0, 1);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k % 2 == 0) begin
                chk("clr_rd_inst", int'(bus.inst), 1);
                chk("clr_rd_idx",  int'(bus.idx),  k / 2);
            end else begin
                chk("clr_wr_inst",   int'(bus.inst),   0);
                chk("clr_wr_idx",    int'(bus.idx),    k / 2);
                chk("clr_wr_xorval", int'(bus.xorval), int'(pat[k / 2]));
            end
        end
        @(negedge clk);
        chk("clr_end_inst",  int'(bus.inst),      3);
        chk("clr_end_ready", int'(bus.req_ready), 1);
        issue(OP_QRY, 3'd0, 3'd7, 1'b0, 1);
        wait_idle();

        // Reset during QL: the response is dropped.
        issue(OP_UPD, 3'd1, 3'd0, 1'b1, 1);
        issue(OP_UPD, 3'd5, 3'd0, 1'b1, 1);
        issue(OP_QRY, 3'd2, 3'd6, 1'b0, 0);
        @(posedge clk); #1;
        chk("rq_ql_idx", int'(bus.idx), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rq_ready",      int'(bus.req_ready),  1);
        chk("rq_inst",       int'(bus.inst),       3);
        chk("rq_resp_valid", int'(bus.resp_valid), 0);
        repeat (4) begin
            @(negedge clk);
            chk("rq_no_resp", int'(bus.resp_valid), 0);
        end

        // Reset during clear at entry 4: entries 0..3 cleared, the rest untouched.
        issue(OP_CLR, 3'd0, 3'd0, 1'b0, 0);
        repeat (8) @(posedge clk);
        #1;
        chk("rc_rd4_inst", int'(bus.inst), 1);
        chk("rc_rd4_idx",  int'(bus.idx),  4);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        shadow[3:0] = 4'h0;
        @(negedge clk);
        chk("rc_ready", int'(bus.req_ready), 1);
        chk("rc_inst",  int'(bus.inst),      3);
        repeat (3) begin
            @(negedge clk);
            chk("rc_bus_idle", int'(bus.inst), 3);
        end
        issue(OP_QRY, 3'd0, 3'd7, 1'b0, 1);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
